// File: rtl/gpio_in_filter_pkg.sv
// gpio_in_filter_pkg
//   Shared SoC-level constants and types for the GPIO input filter.
//   SOC_LEN_DATA_IO   : default number of GPIO input bits.
//   ENABLE / DISABLE  : polarity of the debounce advance enable.
//   SOC_DB_CYCLES     : default debounce length in enabled clock cycles.
//   db_event_e        : per-bit outcome of one debounce step.
//   db_cnt_width()    : debounce counter width, never below one bit.
package gpio_in_filter_pkg;

   localparam int unsigned SOC_LEN_DATA_IO = 32;
   localparam logic        ENABLE          = 1'b1;
   localparam logic        DISABLE         = 1'b0;
   localparam int unsigned SOC_DB_CYCLES   = 4;
   localparam int unsigned DB_CYCLES_MAX   = 65535;

   typedef enum logic [1:0] {
      EvNone = 2'd0,
      EvRise = 2'd1,
      EvFall = 2'd2
   } db_event_e;

   function automatic int unsigned db_cnt_width(input int unsigned cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/gpio_in_filter_db_bit.sv
// gpio_db_bit
//   One GPIO input bit: two-flop synchronizer, debounce counter, stable level
//   and one-cycle edge pulses.
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset
//   en_i      : debounce advance enable (synchronizer runs regardless)
//   pin_i     : raw asynchronous pin
//   stable_o  : debounced level (registered)
//   rise_o    : one-cycle 0->1 pulse (registered)
//   fall_o    : one-cycle 1->0 pulse (registered)
//   pulse_d_o : next-state of rise|fall, for the top-level changed flag
module gpio_db_bit
   import gpio_in_filter_pkg::*;
#(
   parameter int unsigned DB_CYCLES = SOC_DB_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic pin_i,
   output logic stable_o,
   output logic rise_o,
   output logic fall_o,
   output logic pulse_d_o
);

   localparam int unsigned CntW = db_cnt_width(DB_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, stable_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;
   db_event_e       evt_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      evt_d    = EvNone;
      if (en_i == ENABLE) begin
         if (sync2_q == stable_q) begin
            cnt_d = '0;
         end else if (cnt_q == CntLast) begin
            // New level has persisted long enough: commit it and flag the edge.
            stable_d = sync2_q;
            cnt_d    = '0;
            evt_d    = sync2_q ? EvRise : EvFall;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_comb begin
      rise_d = 1'b0;
      fall_d = 1'b0;
      unique case (evt_d)
         EvRise:  rise_d = 1'b1;
         EvFall:  fall_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         sync1_q  <= pin_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
      end
   end

   assign stable_o  = stable_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign pulse_d_o = rise_d | fall_d;

endmodule

// File: rtl/gpio_in_filter.sv
// gpio_in_filter
//   Debounces LEN_DATA_IO asynchronous board pins into a stable GPIO_IR level
//   with per-bit rise/fall pulses and a global changed flag. All outputs are
//   registered; there is no combinational path from pin_in.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   en      : debounce advance enable
//   pin_in  : raw board pins
//   GPIO_IR : debounced level, feeds the IO register block
//   rise    : per-bit one-cycle 0->1 pulse
//   fall    : per-bit one-cycle 1->0 pulse
//   changed : OR of rise|fall, registered alongside them
module gpio_in_filter
   import gpio_in_filter_pkg::*;
#(
   parameter int unsigned LEN_DATA_IO = SOC_LEN_DATA_IO,
   parameter int unsigned DB_CYCLES   = SOC_DB_CYCLES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [LEN_DATA_IO-1:0] pin_in,
   output logic [LEN_DATA_IO-1:0] GPIO_IR,
   output logic [LEN_DATA_IO-1:0] rise,
   output logic [LEN_DATA_IO-1:0] fall,
   output logic                   changed
);

   logic [LEN_DATA_IO-1:0] pulse_d;
   logic                   changed_q, changed_d;

   for (genvar i = 0; i < LEN_DATA_IO; i++) begin : g_bit
      gpio_db_bit #(
         .DB_CYCLES (DB_CYCLES)
      ) u_db_bit (
         .clk_i     (clk),
         .rst_i     (rst),
         .en_i      (en),
         .pin_i     (pin_in[i]),
         .stable_o  (GPIO_IR[i]),
         .rise_o    (rise[i]),
         .fall_o    (fall[i]),
         .pulse_d_o (pulse_d[i])
      );
   end

   // Built from next-state pulses so changed lands in the same cycle as rise/fall.
   always_comb begin
      changed_d = |pulse_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         changed_q <= 1'b0;
      end else begin
         changed_q <= changed_d;
      end
   end

   assign changed = changed_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
module tb_gpio_in_filter;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] pin_in;
   logic [31:0] GPIO_IR, rise, fall;
   logic        changed;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int          cyc;
      logic [31:0] gpio;
      logic [31:0] rise;
      logic [31:0] fall;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   gpio_in_filter #(
      .LEN_DATA_IO (32),
      .DB_CYCLES   (4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .pin_in  (pin_in),
      .GPIO_IR (GPIO_IR),
      .rise    (rise),
      .fall    (fall),
      .changed (changed)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   // Expect an output event 'delta' active edges after the current negedge.
   task automatic expect_in(input int delta, input logic [31:0] g, input logic [31:0] r,
                            input logic [31:0] f);
      exp_t x;
      x.cyc  = edge_n + delta;
      x.gpio = g;
      x.rise = r;
      x.fall = f;
      exp_q.push_back(x);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h (edge %0d)", name, act, want, edge_n);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: invariants every cycle, scoreboard pop whenever a pulse appears.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ((rise & fall) !== 32'h0) begin
            errors++;
            $display("FAIL rise_fall_excl: rise %h fall %h (edge %0d)", rise, fall, edge_n);
         end
         checks++;
         if (changed !== (|(rise | fall))) begin
            errors++;
            $display("FAIL changed_or: changed %b rise %h fall %h (edge %0d)",
                     changed, rise, fall, edge_n);
         end
         if (changed || ((rise | fall) != 32'h0)) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse: gpio %h rise %h fall %h (edge %0d)",
                        GPIO_IR, rise, fall, edge_n);
            end else begin
               e = exp_q.pop_front();
               if (edge_n != e.cyc || GPIO_IR !== e.gpio || rise !== e.rise ||
                   fall !== e.fall) begin
                  errors++;
                  $display("FAIL event: got edge %0d gpio %h rise %h fall %h, want edge %0d gpio %h rise %h fall %h",
                           edge_n, GPIO_IR, rise, fall, e.cyc, e.gpio, e.rise, e.fall);
               end
            end
         end
      end
   end

   initial begin
      rst    = 1'b1;
      en     = 1'b1;
      pin_in = 32'h0;
      ticks(3);
      chk("reset_gpio", GPIO_IR, 32'h0);
      chk("reset_rise", rise, 32'h0);
      chk("reset_fall", fall, 32'h0);
      chk("reset_changed", {31'h0, changed}, 32'h0);
      mon_en = 1'b1;
      rst    = 1'b0;
      ticks(8);

      // Clean step on bit 0.
      pin_in = 32'h1;
      expect_in(6, 32'h1, 32'h1, 32'h0);
      ticks(5);
      chk("step_not_early", GPIO_IR, 32'h0);
      ticks(5);

      // Glitch on bit 3 for three cycles.
      pin_in = 32'h9;
      ticks(3);
      pin_in = 32'h1;
      ticks(10);
      chk("glitch_rejected", GPIO_IR, 32'h1);

      // Multi-bit transitions.
      pin_in = 32'h0F;
      expect_in(6, 32'h0F, 32'h0E, 32'h0);
      ticks(10);
      pin_in = 32'hF0;
      expect_in(6, 32'hF0, 32'hF0, 32'h0F);
      ticks(10);

      // Enable gating: step while disabled, then release.
      en     = 1'b0;
      pin_in = 32'h0;
      ticks(12);
      chk("gate_hold", GPIO_IR, 32'hF0);
      en = 1'b1;
      expect_in(4, 32'h0, 32'h0, 32'hF0);
      ticks(3);
      chk("gate_not_early", GPIO_IR, 32'hF0);
      ticks(7);

      // Reset mid-count (cnt=2 at this point).
      pin_in = 32'hFFFF_FFFF;
      ticks(4);
      rst = 1'b1;
      ticks(1);
      chk("midrst_gpio", GPIO_IR, 32'h0);
      chk("midrst_rise", rise, 32'h0);
      chk("midrst_fall", fall, 32'h0);
      chk("midrst_changed", {31'h0, changed}, 32'h0);
      rst = 1'b0;
      expect_in(6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
      ticks(5);
      chk("midrst_not_early", GPIO_IR, 32'h0);
      ticks(5);

      // Drop bit 0, then bounce it before settling high.
      pin_in = 32'hFFFF_FFFE;
      expect_in(6, 32'hFFFF_FFFE, 32'h0, 32'h1);
      ticks(10);
      for (int c = 0; c < 20; c++) begin
         pin_in = {31'h7FFF_FFFF, ((c / 2) % 2) == 0};
         ticks(1);
      end
      pin_in = 32'hFFFF_FFFF;
      expect_in(6, 32'hFFFF_FFFF, 32'h1, 32'h0);
      ticks(10);
      chk("bounce_final", GPIO_IR, 32'hFFFF_FFFF);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: %0d expected events never seen, want 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
